// File: rtl/elastic_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// elastic_pipe_reg_pkg
// Shared definitions for the elastic pipeline register family.
//   NOP_INSN        : default bubble word for instruction-word instances
//                     (RISC-V "addi x0, x0, 0").
//   stage_state_e   : occupancy state of one two-entry skid stage.
//   pipeClog2()     : constant-foldable ceil(log2) for parameter defaults.
//   stateOccupancy(): number of valid entries held in a given stage state.
// ---------------------------------------------------------------------------
package elastic_pipe_reg_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Bounded loop so it folds as a constant function on any elaborator.
  function automatic int pipeClog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic [1:0] stateOccupancy(input stage_state_e state);
    logic [1:0] count;
    case (state)
      ST_ONE:  count = 2'd1;
      ST_TWO:  count = 2'd2;
      default: count = 2'd0;
    endcase
    return count;
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// elastic_pipe_reg_if
// Valid/ready handshake bundle carrying a WIDTH-bit payload.
//   valid : producer has a payload
//   ready : consumer can accept
//   data  : payload, held stable by the producer until accepted
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : consumer side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface elastic_pipe_reg_if #(
  parameter int WIDTH = 16
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/elastic_pipe_reg_stage.sv
// ---------------------------------------------------------------------------
// elastic_pipe_stage
// One elastic stage with a main register and a skid register. Both ready and
// valid outputs come straight from state, so there is no combinational path
// from out_ready_i to in_ready_o, nor from the input side to the output side.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush_i                 : synchronous flush, empties the stage
//   in_valid_i/in_ready_o   : upstream handshake
//   in_data_i               : upstream payload
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o              : downstream payload (main register)
//   occ_o                   : entries held in this stage (0..2)
// ---------------------------------------------------------------------------
module elastic_pipe_stage
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] mainData_q, mainData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             inXfer;
  logic             outXfer;

  // The skid entry is what makes ready independent of out_ready: a stage in
  // ONE can still take a beat even if downstream stalls that same cycle.
  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = mainData_q;
  assign occ_o       = stateOccupancy(state_q);

  assign inXfer  = in_valid_i & in_ready_o;
  assign outXfer = out_valid_o & out_ready_i;

  // State and data registers; skid data is reset only for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      mainData_q <= FLUSH_VAL;
      skidData_q <= FLUSH_VAL;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
    end
  end

  // Next-state logic. Flush wins over every transfer; a beat accepted in the
  // flush cycle is simply dropped, and an outgoing beat completes downstream.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    if (flush_i) begin
      state_d    = ST_EMPTY;
      mainData_d = FLUSH_VAL;
      skidData_d = FLUSH_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (inXfer) begin
            state_d    = ST_ONE;
            mainData_d = in_data_i;
          end
        end
        ST_ONE: begin
          if (inXfer && outXfer) begin
            mainData_d = in_data_i;
          end else if (inXfer) begin
            state_d    = ST_TWO;
            skidData_d = in_data_i;
          end else if (outXfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only the drain case exists.
          if (outXfer) begin
            state_d    = ST_ONE;
            mainData_d = skidData_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// ---------------------------------------------------------------------------
// elastic_pipe_reg
// Chain of STAGES elastic skid stages between two CPU pipeline stages. Keeps
// full throughput with back-pressure, strict FIFO order, total capacity
// 2*STAGES, synchronous flush to a bubble value and an occupancy count.
// Parameters:
//   WIDTH     : payload width (>=1)
//   STAGES    : number of chained stages (1..8); latency is STAGES cycles
//   FLUSH_VAL : value of every main data register after reset/flush
//   OCC_W     : occupancy width, derived from STAGES
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : synchronous flush, discards every held entry
//   in_if       : upstream handshake (this block is the consumer)
//   out_if      : downstream handshake (this block is the producer)
//   occupancy_o : entries held across all stages (0..2*STAGES)
// ---------------------------------------------------------------------------
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               OCC_W     = pipeClog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  elastic_pipe_reg_if.slave  in_if,
  elastic_pipe_reg_if.master out_if,
  output logic [OCC_W-1:0] occupancy_o
);

  // Index k is the input side of stage k; index STAGES is the block output.
  logic [STAGES:0]              stageValid;
  logic [STAGES:0]              stageReady;
  logic [STAGES:0][WIDTH-1:0]   stageData;
  logic [STAGES-1:0][1:0]       stageOcc;
  logic [OCC_W-1:0]             occSum;

  assign stageValid[0]      = in_if.valid;
  assign stageData[0]       = in_if.data;
  assign in_if.ready        = stageReady[0];
  assign out_if.valid       = stageValid[STAGES];
  assign out_if.data        = stageData[STAGES];
  assign stageReady[STAGES] = out_if.ready;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    elastic_pipe_stage #(
      .WIDTH     (WIDTH),
      .FLUSH_VAL (FLUSH_VAL)
    ) uStage (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid_i  (stageValid[k]),
      .in_ready_o  (stageReady[k]),
      .in_data_i   (stageData[k]),
      .out_valid_o (stageValid[k+1]),
      .out_ready_i (stageReady[k+1]),
      .out_data_o  (stageData[k+1]),
      .occ_o       (stageOcc[k])
    );
  end

  // Occupancy is the sum of per-stage counts, which are registered state, so
  // it moves on the same edge as the transfers that change it.
  always_comb begin
    occSum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occSum = occSum + OCC_W'(stageOcc[i]);
    end
  end

  assign occupancy_o = occSum;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipe_reg
// Directed bench for elastic_pipe_reg with three instances:
//   A : STAGES=2, FLUSH_VAL=0      (streaming, back-pressure, async reset)
//   B : STAGES=1, FLUSH_VAL=0xF000 (flush, steady flow in state ONE)
//   C : STAGES=3, FLUSH_VAL=0      (random valid/ready against a queue)
// ---------------------------------------------------------------------------
module tb_elastic_pipe_reg;

  logic       clk;
  logic       rstN;
  logic       flushA, flushB, flushC;
  logic [2:0] occA;
  logic [1:0] occB;
  logic [2:0] occC;

  int checkCount;
  int errorCount;

  elastic_pipe_reg_if #(.WIDTH(16)) aIn ();
  elastic_pipe_reg_if #(.WIDTH(16)) aOut ();
  elastic_pipe_reg_if #(.WIDTH(16)) bIn ();
  elastic_pipe_reg_if #(.WIDTH(16)) bOut ();
  elastic_pipe_reg_if #(.WIDTH(16)) cIn ();
  elastic_pipe_reg_if #(.WIDTH(16)) cOut ();

  elastic_pipe_reg #(.WIDTH(16), .STAGES(2), .FLUSH_VAL(16'h0000)) dutA (
    .clk         (clk),
    .rst_n       (rstN),
    .flush_i     (flushA),
    .in_if       (aIn),
    .out_if      (aOut),
    .occupancy_o (occA)
  );

  elastic_pipe_reg #(.WIDTH(16), .STAGES(1), .FLUSH_VAL(16'hF000)) dutB (
    .clk         (clk),
    .rst_n       (rstN),
    .flush_i     (flushB),
    .in_if       (bIn),
    .out_if      (bOut),
    .occupancy_o (occB)
  );

  elastic_pipe_reg #(.WIDTH(16), .STAGES(3), .FLUSH_VAL(16'h0000)) dutC (
    .clk         (clk),
    .rst_n       (rstN),
    .flush_i     (flushC),
    .in_if       (cIn),
    .out_if      (cOut),
    .occupancy_o (occC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive instance A's inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic outReady);
    aIn.valid  = valid;
    aIn.data   = data;
    aOut.ready = outReady;
    @(posedge clk);
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    int          acc;
    logic [15:0] expData;
    logic [15:0] scoreQ[$];
    logic        inX, outX, irBefore;

    checkCount = 0;
    errorCount = 0;
    rstN   = 1'b0;
    flushA = 1'b0; flushB = 1'b0; flushC = 1'b0;
    aIn.valid = 1'b0; aIn.data = '0; aOut.ready = 1'b0;
    bIn.valid = 1'b0; bIn.data = '0; bOut.ready = 1'b0;
    cIn.valid = 1'b0; cIn.data = '0; cOut.ready = 1'b0;

    #22 rstN = 1'b1;
    stepClock();

    // Reset state
    checkOutput("rst_outValidA", 32'(aOut.valid), 32'd0);
    checkOutput("rst_outDataA",  32'(aOut.data),  32'h0000);
    checkOutput("rst_occA",      32'(occA),       32'd0);
    checkOutput("rst_inReadyA",  32'(aIn.ready),  32'd1);
    checkOutput("rst_outDataB",  32'(bOut.data),  32'hF000);
    checkOutput("rst_outValidB", 32'(bOut.valid), 32'd0);

    // Streaming 1..8 through two stages with out_ready held high
    $display("[TB] stream test");
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(c <= 8, 16'(c), 1'b1);
      checkOutput("stream_outValid", 32'(aOut.valid), 32'((c >= 2) && (c <= 9)));
      if ((c >= 2) && (c <= 9)) begin
        checkOutput("stream_outData", 32'(aOut.data), 32'(c - 1));
      end
      checkOutput("stream_inReady", 32'(aIn.ready), 32'd1);
      checkOutput("stream_occ", 32'(occA),
                  (c == 1) ? 32'd1 : (c <= 8) ? 32'd2 : (c == 9) ? 32'd1 : 32'd0);
    end

    // Back-pressure fill: exactly four beats accepted, then drained in order
    $display("[TB] back-pressure test");
    acc = 0;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b1, 16'(acc + 1), 1'b0);
      if (acc < 4) acc++;
      checkOutput("fill_inReady", 32'(aIn.ready), 32'(acc < 4));
      checkOutput("fill_occ",     32'(occA),      32'(acc));
    end
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_outValid", 32'(aOut.valid), 32'd1);
      checkOutput("drain_outData",  32'(aOut.data),  32'(k));
      applyStimulus(1'b0, 16'h0000, 1'b1);
    end
    checkOutput("drain_emptyValid", 32'(aOut.valid), 32'd0);
    checkOutput("drain_emptyOcc",   32'(occA),       32'd0);

    // Flush of a full single stage with a beat offered in the flush cycle
    $display("[TB] flush test");
    bOut.ready = 1'b0;
    bIn.valid  = 1'b1;
    bIn.data   = 16'hAAAA;
    stepClock();
    bIn.data   = 16'hBBBB;
    stepClock();
    checkOutput("flushFull_occ",     32'(occB),      32'd2);
    checkOutput("flushFull_inReady", 32'(bIn.ready), 32'd0);
    flushB   = 1'b1;
    bIn.data = 16'hBEEF;
    stepClock();
    flushB    = 1'b0;
    bIn.valid = 1'b0;
    checkOutput("flush_outValid", 32'(bOut.valid), 32'd0);
    checkOutput("flush_outData",  32'(bOut.data),  32'hF000);
    checkOutput("flush_occ",      32'(occB),       32'd0);
    checkOutput("flush_inReady",  32'(bIn.ready),  32'd1);
    bOut.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput("flush_noBeef", 32'(bOut.valid), 32'd0);
    end

    // Flush in state ONE while a beat is accepted and one is emitted
    bIn.valid = 1'b1;
    bIn.data  = 16'h1111;
    stepClock();
    checkOutput("flushOne_occBefore", 32'(occB), 32'd1);
    flushB   = 1'b1;
    bIn.data = 16'hBEEF;
    stepClock();
    flushB    = 1'b0;
    bIn.valid = 1'b0;
    checkOutput("flushOne_occ",      32'(occB),       32'd0);
    checkOutput("flushOne_outValid", 32'(bOut.valid), 32'd0);
    checkOutput("flushOne_outData",  32'(bOut.data),  32'hF000);
    stepClock();
    checkOutput("flushOne_dropped",  32'(bOut.valid), 32'd0);

    // Steady flow in state ONE: skid never fills
    $display("[TB] steady-flow test");
    bOut.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bIn.valid = 1'b1;
      bIn.data  = 16'(16'h0100 + i);
      stepClock();
      checkOutput("steady_occ",     32'(occB),      32'd1);
      checkOutput("steady_inReady", 32'(bIn.ready), 32'd1);
      checkOutput("steady_outData", 32'(bOut.data), 32'(16'h0100 + i));
    end
    bIn.valid = 1'b0;
    stepClock();
    checkOutput("steady_endOcc", 32'(occB), 32'd0);

    // Asynchronous reset with three entries held
    $display("[TB] async reset test");
    applyStimulus(1'b1, 16'h0011, 1'b0);
    applyStimulus(1'b1, 16'h0022, 1'b0);
    applyStimulus(1'b1, 16'h0033, 1'b0);
    checkOutput("arst_occBefore", 32'(occA), 32'd3);
    aIn.valid = 1'b0;
    #3 rstN = 1'b0;
    #1;
    checkOutput("arst_outValid", 32'(aOut.valid), 32'd0);
    checkOutput("arst_outData",  32'(aOut.data),  32'h0000);
    checkOutput("arst_occ",      32'(occA),       32'd0);
    checkOutput("arst_outDataB", 32'(bOut.data),  32'hF000);
    @(negedge clk);
    rstN = 1'b1;
    stepClock();
    checkOutput("arst_inReady", 32'(aIn.ready), 32'd1);
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("arst_lat1Valid", 32'(aOut.valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("arst_lat2Valid", 32'(aOut.valid), 32'd1);
    checkOutput("arst_lat2Data",  32'(aOut.data),  32'h1234);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("arst_afterValid", 32'(aOut.valid), 32'd0);

    // Random valid/ready on three stages against an in-order queue
    $display("[TB] random test");
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      inX  = cIn.valid & cIn.ready;
      outX = cOut.valid & cOut.ready;
      if (outX) begin
        checkOutput("rand_emitNonEmpty", 32'(scoreQ.size() != 0), 32'd1);
        if (scoreQ.size() != 0) begin
          expData = scoreQ.pop_front();
          checkOutput("rand_data", 32'(cOut.data), 32'(expData));
        end
      end
      if (inX) scoreQ.push_back(cIn.data);
      stepClock();
      checkOutput("rand_occ", 32'(occC), 32'(scoreQ.size()));
      if (inX || !cIn.valid) begin
        cIn.valid = ($urandom_range(0, 3) != 0);
        cIn.data  = 16'($urandom);
      end
      irBefore   = cIn.ready;
      cOut.ready = ($urandom_range(0, 2) != 0);
      #1;
      checkOutput("rand_noCombReady", 32'(cIn.ready), 32'(irBefore));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
